instruction_decode: RTL and testbench

ID stage of the 5-stage RISC-V pipeline. It consumes the IF/ID register (pc, inst) and contains the 32x32 register file, the control decoder and the immediate generator. It detects load-use and branch hazards and resolves beq in ID, driving pc_write, IF_ID_write, IF_flush, pc_src and pc_branch back to fetch. It registers the ID/EX pipeline register consumed by the execute stage.

---
 rtl/instruction_decode_if.sv | 58 +++++
 rtl/instruction_decode.sv | 192 +++++++++++++++++++
 tb/tb_instruction_decode.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_decode_if.sv
// ID-stage bus bundle: IF/ID inputs, hazard feedback, writeback port,
// fetch-control outputs and the ID/EX pipeline register fields.
interface instruction_decode_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] IF_ID_pc;
  logic [31:0]     IF_ID_inst;
  logic            ID_EX_mem_read_i;
  logic            ID_EX_reg_write_i;
  logic [4:0]      ID_EX_rd_i;
  logic            EX_MEM_mem_read;
  logic            EX_MEM_reg_write;
  logic [4:0]      EX_MEM_rd;
  logic [XLEN-1:0] EX_MEM_alu_result;
  logic            wb_reg_write;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  logic            pc_write;
  logic            IF_ID_write;
  logic            IF_flush;
  logic            pc_src;
  logic [XLEN-1:0] pc_branch;
  logic [XLEN-1:0] ID_EX_rs1_data;
  logic [XLEN-1:0] ID_EX_rs2_data;
  logic [XLEN-1:0] ID_EX_imm;
  logic [4:0]      ID_EX_rs1;
  logic [4:0]      ID_EX_rs2;
  logic [4:0]      ID_EX_rd;
  logic [1:0]      ID_EX_alu_ctrl;
  logic            ID_EX_alu_src;
  logic            ID_EX_mem_read;
  logic            ID_EX_mem_write;
  logic            ID_EX_reg_write;
  logic            ID_EX_mem_to_reg;

  // Pipeline side: drives IF/ID, hazard feedback and writeback.
  modport master (
    output IF_ID_pc, IF_ID_inst, ID_EX_mem_read_i, ID_EX_reg_write_i, ID_EX_rd_i,
           EX_MEM_mem_read, EX_MEM_reg_write, EX_MEM_rd, EX_MEM_alu_result,
           wb_reg_write, wb_rd, wb_data,
    input  pc_write, IF_ID_write, IF_flush, pc_src, pc_branch,
           ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm, ID_EX_rs1, ID_EX_rs2, ID_EX_rd,
           ID_EX_alu_ctrl, ID_EX_alu_src, ID_EX_mem_read, ID_EX_mem_write,
           ID_EX_reg_write, ID_EX_mem_to_reg
  );

  // Decode stage side.
  modport slave (
    input  IF_ID_pc, IF_ID_inst, ID_EX_mem_read_i, ID_EX_reg_write_i, ID_EX_rd_i,
           EX_MEM_mem_read, EX_MEM_reg_write, EX_MEM_rd, EX_MEM_alu_result,
           wb_reg_write, wb_rd, wb_data,
    output pc_write, IF_ID_write, IF_flush, pc_src, pc_branch,
           ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm, ID_EX_rs1, ID_EX_rs2, ID_EX_rd,
           ID_EX_alu_ctrl, ID_EX_alu_src, ID_EX_mem_read, ID_EX_mem_write,
           ID_EX_reg_write, ID_EX_mem_to_reg
  );
endinterface

// File: rtl/instruction_decode.sv
// RISC-V ID stage: register file, control decode, immediates, hazard detection,
// beq resolution and ID/EX register. Define BRANCH_FWD_EN to forward EX/MEM ALU results into beq.
module instruction_decode #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input logic                 clk,
  input logic                 reset_n,
  instruction_decode_if.slave bus
);

`ifdef BRANCH_FWD_EN
  localparam bit BranchFwd = 1'b1;
`else
  localparam bit BranchFwd = 1'b0;
`endif

  typedef enum logic [6:0] {
    OP_R   = 7'b0110011,
    OP_I   = 7'b0010011,
    OP_LD  = 7'b0000011,
    OP_ST  = 7'b0100011,
    OP_BEQ = 7'b1100011
  } opcode_e;

  typedef struct packed {
    logic [1:0] alu_ctrl;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    ctrl_t           ctrl;
  } id_ex_t;

  logic [XLEN-1:0] r_regs [NREG];
  id_ex_t          r_id_ex;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm;
  ctrl_t           w_ctrl;
  logic            w_uses_rs2, w_is_beq;
  logic [XLEN-1:0] w_rs1_val, w_rs2_val, w_cmp1, w_cmp2;
  logic            w_exm_hit1, w_exm_hit2, w_fwd_ok;
  logic            w_load_use, w_branch_stall, w_stall, w_taken;

  assign w_opcode = bus.IF_ID_inst[6:0];
  assign w_funct3 = bus.IF_ID_inst[14:12];
  assign w_rd     = bus.IF_ID_inst[11:7];
  assign w_rs1    = bus.IF_ID_inst[19:15];
  assign w_rs2    = bus.IF_ID_inst[24:20];

  assign w_imm_i = {{(XLEN-12){bus.IF_ID_inst[31]}}, bus.IF_ID_inst[31:20]};
  assign w_imm_s = {{(XLEN-12){bus.IF_ID_inst[31]}}, bus.IF_ID_inst[31:25], bus.IF_ID_inst[11:7]};
  assign w_imm_b = {{(XLEN-13){bus.IF_ID_inst[31]}}, bus.IF_ID_inst[31], bus.IF_ID_inst[7],
                    bus.IF_ID_inst[30:25], bus.IF_ID_inst[11:8], 1'b0};

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_ctrl     = '0;
    w_imm      = '0;
    w_uses_rs2 = 1'b0;
    w_is_beq   = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_uses_rs2         = 1'b1;
        w_ctrl.reg_write   = 1'b1;
        case (w_funct3)
          3'b111:  w_ctrl.alu_ctrl = 2'b10;
          3'b110:  w_ctrl.alu_ctrl = 2'b11;
          default: w_ctrl.alu_ctrl = bus.IF_ID_inst[30] ? 2'b01 : 2'b00;
        endcase
      end
      OP_I: begin
        w_imm            = w_imm_i;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
      end
      OP_LD: begin
        w_imm             = w_imm_i;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.mem_read   = 1'b1;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
      end
      OP_ST: begin
        w_imm            = w_imm_s;
        w_uses_rs2       = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        w_imm           = w_imm_b;
        w_uses_rs2      = 1'b1;
        w_is_beq        = 1'b1;
        w_ctrl.alu_ctrl = 2'b01;
      end
      default: ;
    endcase
  end

  // Register file reads: x0 is zero, a same-cycle writeback is bypassed through.
  always_comb begin
    w_rs1_val = r_regs[w_rs1];
    w_rs2_val = r_regs[w_rs2];
    if (w_rs1 == 5'd0)
      w_rs1_val = '0;
    else if (bus.wb_reg_write && bus.wb_rd == w_rs1)
      w_rs1_val = bus.wb_data;
    if (w_rs2 == 5'd0)
      w_rs2_val = '0;
    else if (bus.wb_reg_write && bus.wb_rd == w_rs2)
      w_rs2_val = bus.wb_data;
  end

  // NOTE: the register file is reset explicitly because architectural state must
  // read as zero after reset; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (bus.wb_reg_write && bus.wb_rd != 5'd0) begin
      r_regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  assign w_load_use = bus.ID_EX_mem_read_i && bus.ID_EX_rd_i != 5'd0 &&
                      (bus.ID_EX_rd_i == w_rs1 || (w_uses_rs2 && bus.ID_EX_rd_i == w_rs2));

  assign w_exm_hit1 = bus.EX_MEM_reg_write && bus.EX_MEM_rd != 5'd0 && bus.EX_MEM_rd == w_rs1;
  assign w_exm_hit2 = bus.EX_MEM_reg_write && bus.EX_MEM_rd != 5'd0 && bus.EX_MEM_rd == w_rs2;
  // A load in MEM has no value yet, so it can never be forwarded.
  assign w_fwd_ok   = BranchFwd && !bus.EX_MEM_mem_read;

  assign w_branch_stall = w_is_beq && (
      (bus.ID_EX_reg_write_i && bus.ID_EX_rd_i != 5'd0 &&
       (bus.ID_EX_rd_i == w_rs1 || bus.ID_EX_rd_i == w_rs2)) ||
      ((w_exm_hit1 || w_exm_hit2) && !w_fwd_ok));

  assign w_stall = w_load_use || w_branch_stall;

  assign w_cmp1  = (w_exm_hit1 && w_fwd_ok) ? bus.EX_MEM_alu_result : w_rs1_val;
  assign w_cmp2  = (w_exm_hit2 && w_fwd_ok) ? bus.EX_MEM_alu_result : w_rs2_val;
  assign w_taken = w_is_beq && !w_stall && (w_cmp1 == w_cmp2);

  assign bus.pc_write    = !w_stall;
  assign bus.IF_ID_write = !w_stall;
  assign bus.pc_src      = w_taken;
  assign bus.IF_flush    = w_taken;
  assign bus.pc_branch   = bus.IF_ID_pc + w_imm_b;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_id_ex <= '0;
    end else begin
      r_id_ex.rs1_data <= w_rs1_val;
      r_id_ex.rs2_data <= w_rs2_val;
      r_id_ex.imm      <= w_imm;
      r_id_ex.rs1      <= w_rs1;
      r_id_ex.rs2      <= w_rs2;
      r_id_ex.rd       <= w_rd;
      r_id_ex.ctrl     <= w_stall ? ctrl_t'('0) : w_ctrl;
    end
  end

  assign bus.ID_EX_rs1_data   = r_id_ex.rs1_data;
  assign bus.ID_EX_rs2_data   = r_id_ex.rs2_data;
  assign bus.ID_EX_imm        = r_id_ex.imm;
  assign bus.ID_EX_rs1        = r_id_ex.rs1;
  assign bus.ID_EX_rs2        = r_id_ex.rs2;
  assign bus.ID_EX_rd         = r_id_ex.rd;
  assign bus.ID_EX_alu_ctrl   = r_id_ex.ctrl.alu_ctrl;
  assign bus.ID_EX_alu_src    = r_id_ex.ctrl.alu_src;
  assign bus.ID_EX_mem_read   = r_id_ex.ctrl.mem_read;
  assign bus.ID_EX_mem_write  = r_id_ex.ctrl.mem_write;
  assign bus.ID_EX_reg_write  = r_id_ex.ctrl.reg_write;
  assign bus.ID_EX_mem_to_reg = r_id_ex.ctrl.mem_to_reg;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: decode, immediates, regfile, load-use and
// branch hazards, beq resolution and asynchronous reset.
module tb_instruction_decode;
  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  instruction_decode_if bus ();

  instruction_decode dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic wb(input logic [4:0] rd, input logic [31:0] data);
    bus.wb_reg_write = 1'b1;
    bus.wb_rd        = rd;
    bus.wb_data      = data;
    tick();
    bus.wb_reg_write = 1'b0;
  endtask

  function automatic logic [6:0] ctrl_bits();
    return {bus.ID_EX_alu_ctrl, bus.ID_EX_alu_src, bus.ID_EX_mem_read,
            bus.ID_EX_mem_write, bus.ID_EX_reg_write, bus.ID_EX_mem_to_reg};
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bus.IF_ID_pc = '0;          bus.IF_ID_inst = '0;
    bus.ID_EX_mem_read_i = 0;   bus.ID_EX_reg_write_i = 0; bus.ID_EX_rd_i = '0;
    bus.EX_MEM_mem_read = 0;    bus.EX_MEM_reg_write = 0;  bus.EX_MEM_rd = '0;
    bus.EX_MEM_alu_result = '0; bus.wb_reg_write = 0;      bus.wb_rd = '0;
    bus.wb_data = '0;

    // Reset state
    #2;
    chk("rst_rs1_data", bus.ID_EX_rs1_data, 32'h0);
    chk("rst_ctrl", {25'd0, ctrl_bits()}, 32'h0);
    chk("rst_pc_write", {31'd0, bus.pc_write}, 32'd1);
    chk("rst_flush_src", {30'd0, bus.IF_flush, bus.pc_src}, 32'd0);
    #10;
    reset_n = 1'b1;
    tick();

    wb(5'd12, 32'd5);
    wb(5'd14, 32'd7);
    wb(5'd1,  32'd3);
    wb(5'd10, 32'd3);

    // add x8,x12,x14
    bus.IF_ID_inst = enc_r(7'h00, 5'd14, 5'd12, 3'b000, 5'd8);
    tick();
    chk("add_rs1_data", bus.ID_EX_rs1_data, 32'd5);
    chk("add_rs2_data", bus.ID_EX_rs2_data, 32'd7);
    chk("add_rd", {27'd0, bus.ID_EX_rd}, 32'd8);
    chk("add_ctrl", {25'd0, ctrl_bits()}, 32'b00_0_0_0_1_0);

    // sub x9,x14,x12 / or / and
    bus.IF_ID_inst = enc_r(7'h20, 5'd12, 5'd14, 3'b000, 5'd9);
    tick();
    chk("sub_ctrl", {25'd0, ctrl_bits()}, 32'b01_0_0_0_1_0);
    chk("sub_rs1_data", bus.ID_EX_rs1_data, 32'd7);
    bus.IF_ID_inst = enc_r(7'h00, 5'd14, 5'd12, 3'b110, 5'd9);
    tick();
    chk("or_alu", {30'd0, bus.ID_EX_alu_ctrl}, 32'b11);
    bus.IF_ID_inst = enc_r(7'h00, 5'd14, 5'd12, 3'b111, 5'd9);
    tick();
    chk("and_alu", {30'd0, bus.ID_EX_alu_ctrl}, 32'b10);

    // addi x15,x10,-50
    bus.IF_ID_inst = enc_i(12'hFCE, 5'd10, 3'b000, 5'd15, 7'b0010011);
    tick();
    chk("addi_imm", bus.ID_EX_imm, 32'hFFFF_FFCE);
    chk("addi_ctrl", {25'd0, ctrl_bits()}, 32'b00_1_0_0_1_0);
    chk("addi_rs1_data", bus.ID_EX_rs1_data, 32'd3);

    // sw x14,4(x2)
    bus.IF_ID_inst = enc_s(12'd4, 5'd14, 5'd2);
    tick();
    chk("sw_imm", bus.ID_EX_imm, 32'd4);
    chk("sw_ctrl", {25'd0, ctrl_bits()}, 32'b00_1_0_1_0_0);
    chk("sw_rs2_data", bus.ID_EX_rs2_data, 32'd7);

    // lw x9,-4(x12)
    bus.IF_ID_inst = enc_i(12'hFFC, 5'd12, 3'b010, 5'd9, 7'b0000011);
    tick();
    chk("lw_imm", bus.ID_EX_imm, 32'hFFFF_FFFC);
    chk("lw_ctrl", {25'd0, ctrl_bits()}, 32'b00_1_1_0_1_1);

    // Load-use stall on rs2: sub x5,x19,x14 behind a load to x14
    bus.ID_EX_mem_read_i = 1'b1;
    bus.ID_EX_rd_i       = 5'd14;
    bus.IF_ID_inst       = enc_r(7'h20, 5'd14, 5'd19, 3'b000, 5'd5);
    #1;
    chk("lu_pc_write", {31'd0, bus.pc_write}, 32'd0);
    chk("lu_if_id_write", {31'd0, bus.IF_ID_write}, 32'd0);
    tick();
    chk("lu_bubble_ctrl", {25'd0, ctrl_bits()}, 32'd0);
    bus.ID_EX_mem_read_i = 1'b0;
    #1;
    chk("lu_release_pc_write", {31'd0, bus.pc_write}, 32'd1);
    tick();
    chk("lu_release_ctrl", {25'd0, ctrl_bits()}, 32'b01_0_0_0_1_0);
    chk("lu_release_rd", {27'd0, bus.ID_EX_rd}, 32'd5);

    // addi does not use rs2: imm field 14 must not trigger a stall
    bus.ID_EX_mem_read_i = 1'b1;
    bus.IF_ID_inst       = enc_i(12'd14, 5'd3, 3'b000, 5'd5, 7'b0010011);
    #1;
    chk("lu_addi_no_stall", {31'd0, bus.pc_write}, 32'd1);
    // Load to x0 never stalls
    bus.ID_EX_rd_i = 5'd0;
    bus.IF_ID_inst = enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd5);
    #1;
    chk("lu_x0_no_stall", {31'd0, bus.pc_write}, 32'd1);
    bus.ID_EX_mem_read_i = 1'b0;

    // beq x1,x10,12 at 0x1C, both 3: taken
    bus.IF_ID_pc   = 32'h1C;
    bus.IF_ID_inst = enc_b(13'd12, 5'd10, 5'd1);
    #1;
    chk("beq_pc_src", {31'd0, bus.pc_src}, 32'd1);
    chk("beq_target", bus.pc_branch, 32'h28);
    chk("beq_flush", {31'd0, bus.IF_flush}, 32'd1);
    chk("beq_pc_write", {31'd0, bus.pc_write}, 32'd1);
    tick();
    chk("beq_ctrl", {25'd0, ctrl_bits()}, 32'b01_0_0_0_0_0);
    bus.IF_ID_inst = 32'h0;
    #1;
    chk("nop_flush", {31'd0, bus.IF_flush}, 32'd0);

    // x10 <- 4 seen through the write-through bypass: not taken
    bus.IF_ID_inst   = enc_b(13'd12, 5'd10, 5'd1);
    bus.wb_reg_write = 1'b1;
    bus.wb_rd        = 5'd10;
    bus.wb_data      = 32'd4;
    #1;
    chk("beq_bypass_nt", {30'd0, bus.pc_src, bus.IF_flush}, 32'd0);
    chk("beq_nt_target", bus.pc_branch, 32'h28);
    tick();
    bus.wb_reg_write = 1'b0;
    #1;
    chk("beq_rf_nt", {31'd0, bus.pc_src}, 32'd0);

    // Backward branch beq x1,x1,-8
    bus.IF_ID_inst = enc_b(13'h1FF8, 5'd1, 5'd1);
    #1;
    chk("beq_back_target", bus.pc_branch, 32'h14);
    chk("beq_back_src", {31'd0, bus.pc_src}, 32'd1);
    tick();
    chk("beq_back_imm", bus.ID_EX_imm, 32'hFFFF_FFF8);

    // Stall wins over taken: EX-stage writer of x1
    bus.ID_EX_reg_write_i = 1'b1;
    bus.ID_EX_rd_i        = 5'd1;
    #1;
    chk("bst_a_src_flush", {30'd0, bus.pc_src, bus.IF_flush}, 32'd0);
    chk("bst_a_pc_write", {31'd0, bus.pc_write}, 32'd0);
    tick();
    chk("bst_a_bubble", {25'd0, ctrl_bits()}, 32'd0);
    bus.ID_EX_reg_write_i = 1'b0;
    bus.ID_EX_rd_i        = 5'd0;

    // beq x1,x14 with a load to x14 in MEM: always stalls
    bus.IF_ID_inst        = enc_b(13'd12, 5'd14, 5'd1);
    bus.EX_MEM_reg_write  = 1'b1;
    bus.EX_MEM_mem_read   = 1'b1;
    bus.EX_MEM_rd         = 5'd14;
    bus.EX_MEM_alu_result = 32'd3;
    #1;
    chk("bst_b_load", {30'd0, bus.pc_write, bus.pc_src}, 32'b00);

    // ALU result for x14 in MEM equals x1
    bus.EX_MEM_mem_read = 1'b0;
    #1;
`ifdef BRANCH_FWD_EN
    chk("bfwd_taken", {30'd0, bus.pc_write, bus.pc_src}, 32'b11);
    bus.EX_MEM_reg_write = 1'b0;
`else
    chk("bst_b_stall", {30'd0, bus.pc_write, bus.pc_src}, 32'b00);
    tick();
    bus.EX_MEM_reg_write = 1'b0;
    bus.wb_reg_write     = 1'b1;
    bus.wb_rd            = 5'd14;
    bus.wb_data          = 32'd3;
    #1;
    chk("bst_b_retry_taken", {30'd0, bus.pc_write, bus.pc_src}, 32'b11);
`endif
    tick();

    // Writes to x0 are dropped and bypass does not apply to x0
    bus.wb_reg_write = 1'b1;
    bus.wb_rd        = 5'd0;
    bus.wb_data      = 32'hDEAD_BEEF;
    bus.IF_ID_inst   = enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd6);
    tick();
    chk("x0_bypass", bus.ID_EX_rs1_data, 32'h0);
    bus.wb_reg_write = 1'b0;
    tick();
    chk("x0_read", bus.ID_EX_rs2_data, 32'h0);

    // Asynchronous reset in the middle of a load-use stall
    bus.IF_ID_inst = enc_r(7'h00, 5'd14, 5'd12, 3'b000, 5'd8);
    tick();
    chk("pre_rst_rs1_data", bus.ID_EX_rs1_data, 32'd5);
    bus.ID_EX_mem_read_i = 1'b1;
    bus.ID_EX_rd_i       = 5'd12;
    #1;
    chk("pre_rst_stall", {31'd0, bus.pc_write}, 32'd0);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_data", {bus.ID_EX_rs1_data | bus.ID_EX_rs2_data | bus.ID_EX_imm}, 32'h0);
    chk("rst_mid_idx", {17'd0, bus.ID_EX_rs1, bus.ID_EX_rs2, bus.ID_EX_rd}, 32'h0);
    chk("rst_mid_ctrl", {25'd0, ctrl_bits()}, 32'h0);
    #2;
    reset_n = 1'b1;
    bus.ID_EX_mem_read_i = 1'b0;
    bus.ID_EX_rd_i       = 5'd0;
    tick();
    chk("rst_rf_rs1", bus.ID_EX_rs1_data, 32'h0);
    chk("rst_rf_rs2", bus.ID_EX_rs2_data, 32'h0);
    chk("post_rst_reg_write", {31'd0, bus.ID_EX_reg_write}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
